pixel_window_shift: RTL and testbench
=====================================

Name: pixel_window_shift

Overview:
Parametrised sliding-window pixel shift register with valid/ready handshake on both sides. Accepts one PIX_W-bit pixel per handshake and presents the last TAPS pixels as one packed window, newest pixel in the least-significant slot. Tracks line boundaries so that no window straddles two lines. Sits between the pixel source (RGB or grayscale stream) and the downstream convolution/filter kernels.

Parameters:
PIX_W, 24, bits per pixel (24 = RGB888, 8 = grayscale)
TAPS, 3, pixels per window; legal range 2..16
CNT_W, $clog2(TAPS+1), width of the fill counter (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
s_valid  input  1  input pixel valid
s_ready  output  1  block can accept a pixel this cycle
s_pixel  input  PIX_W  input pixel
s_sol  input  1  pixel is the first of a line; qualified by s_valid
s_eol  input  1  pixel is the last of a line; qualified by s_valid
m_valid  output  1  m_window holds a complete window
m_ready  input  1  downstream accepts the window
m_window  output  PIX_W*TAPS  slot k = bits [PIX_W*(k+1)-1 : PIX_W*k]; slot 0 = newest pixel
m_eol  output  1  newest pixel in window was flagged s_eol
fill  output  CNT_W  pixels of the current line in the window, saturating at TAPS

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: window = 0, fill = 0, m_valid = 0, m_eol = 0. s_ready = 0 while rst is high.
- s_ready = !m_valid || m_ready; it is combinational and forced to 0 during rst.
- accept = s_valid && s_ready.
- On accept:
  - window <= {window[PIX_W*(TAPS-1)-1:0], s_pixel}.
  - fill <= s_sol ? 1 : min(fill+1, TAPS).
  - m_eol <= s_eol.
  - m_valid <= (fill_next == TAPS).
- No accept and m_ready: m_valid <= 0.
- No accept and !m_ready: all state holds.
- Latency is 1 cycle from accept to m_valid. Throughput is 1 window per clock under continuous valid/ready.
- Stalls: while m_valid && !m_ready, m_window, m_eol and fill are stable, and s_ready = 0.
- Line handling:
  - After s_sol, m_valid stays low until TAPS pixels of the new line have been accepted.
  - Older-line slots may remain in m_window but are never presented with m_valid high.
- s_sol and s_eol together on the same pixel (a one-pixel line):
  - Set fill = 1 and m_eol = 1.
  - m_valid = 1 only if TAPS == 1, which is illegal, so m_valid stays 0.
- Next pixel after an eol without s_sol: the line continues, and the window keeps sliding. Upstream must assert s_sol for correct framing.
- Fill saturates at TAPS; there is no wrap-around.
- rst mid-line or mid-stall: state clears on the next edge. Any pending window is discarded and not delivered.
- s_sol and s_eol are ignored when s_valid is low.

Optional Feature:
Macro PIXEL_WINDOW_EDGE_REPLICATE_EN.
- Defined: on accept with s_sol, every slot is loaded with s_pixel and fill <= TAPS. m_valid is therefore 1 on the next cycle, giving border replication so each input pixel yields one window.
- Not defined: the behaviour above, so a line of N pixels yields N-TAPS+1 windows.
- Handshake and latency are identical in both builds.

Decomposition:
- Package pixel_pkg holds:
  - PIX_W_RGB = 24 and PIX_W_GRAY = 8.
  - MAX_TAPS = 16.
  - Function slot_lsb(k, pix_w) returning the bit offset of slot k.
- One sub-module is natural: pixel_fill_cnt, the saturating fill counter with sol load. Everything else stays in the top.

Test Plan (PIX_W=24, TAPS=3 unless noted):
- Fill: rst, then accept sol=A1, then A2, A3 with m_ready=1.
  - m_valid rises 1 cycle after A3.
  - m_window = {A1,A2,A3} with A3 in slot 0; fill = 3.
- Stall: stream 0x000001..0x000006 with m_ready low for 4 cycles after the first window.
  - s_ready = 0 during the stall and m_window holds {1,2,3}.
  - After release, windows {2,3,4}, {3,4,5}, {4,5,6} appear in order, none lost or duplicated.
- Line break: line 10,11,12,13 (13 with eol), then sol 20,21,22.
  - Windows are {10,11,12} and {11,12,13} (m_eol=1), then {20,21,22}.
  - No window mixes 1x with 2x values.
- Reset mid-stall: m_valid=1, m_ready=0, assert rst for 1 cycle.
  - Next cycle m_valid=0, fill=0, m_window=0.
  - The following 3 accepts give the first window.
- With PIXEL_WINDOW_EDGE_REPLICATE_EN: sol 0xFF0000 on a fresh line.
  - 1 cycle later m_valid=1 and m_window = {FF0000,FF0000,FF0000}.
  - Next pixel 0x00FF00 gives {FF0000,FF0000,00FF00}.
- PIX_W=8, TAPS=5: continuous stream 1..7 with s_sol on 1.
  - Exactly 3 windows: {1..5}, {2..6}, {3..7}.

Source files
------------

// File: rtl/pixel_window_shift_pkg.sv
// Shared constants and slot-offset helper for the pixel window shift register.
// Optional build macro used by the window blocks: PIXEL_WINDOW_EDGE_REPLICATE_EN.
package pixel_pkg;
  localparam int PIX_W_RGB  = 24;
  localparam int PIX_W_GRAY = 8;
  localparam int MAX_TAPS   = 16;

  function automatic int slot_lsb(input int k, input int pix_w);
    return k * pix_w;
  endfunction
endpackage

// File: rtl/pixel_window_shift_if.sv
// Pixel-in / window-out bus for pixel_window_shift; the slave modport is the block side.
// Build macro affecting the block behind this bus: PIXEL_WINDOW_EDGE_REPLICATE_EN.
interface pixel_window_shift_if
  import pixel_pkg::*;
#(
  parameter int PIX_W = PIX_W_RGB,
  parameter int TAPS  = 3
);
  localparam int CNT_W = $clog2(TAPS + 1);

  logic                  s_valid;
  logic                  s_ready;
  logic [PIX_W-1:0]      s_pixel;
  logic                  s_sol;
  logic                  s_eol;
  logic                  m_valid;
  logic                  m_ready;
  logic [PIX_W*TAPS-1:0] m_window;
  logic                  m_eol;
  logic [CNT_W-1:0]      fill;

  // Both sides: a transfer happens on a rising edge where valid && ready; a
  // producer holding valid keeps its payload stable until that edge.
  modport slave (
    input  s_valid, s_pixel, s_sol, s_eol, m_ready,
    output s_ready, m_valid, m_window, m_eol, fill
  );

  modport master (
    output s_valid, s_pixel, s_sol, s_eol, m_ready,
    input  s_ready, m_valid, m_window, m_eol, fill
  );
endinterface

// File: rtl/pixel_window_shift_fill_cnt.sv
// Saturating count of current-line pixels held in the window; s_sol restarts it.
// With PIXEL_WINDOW_EDGE_REPLICATE_EN an s_sol loads the full count at once.
module pixel_fill_cnt #(
  parameter int TAPS  = 3,
  parameter int CNT_W = $clog2(TAPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_sol,
  output logic [CNT_W-1:0] o_fill,
  output logic [CNT_W-1:0] o_fill_next
);
  logic [CNT_W-1:0] r_fill;
  logic [CNT_W-1:0] w_fill_next;

  always_comb begin
    w_fill_next = r_fill;
    if (i_sol) begin
`ifdef PIXEL_WINDOW_EDGE_REPLICATE_EN
      w_fill_next = CNT_W'(TAPS);
`else
      w_fill_next = CNT_W'(1);
`endif
    end else if (r_fill == CNT_W'(TAPS)) begin
      w_fill_next = CNT_W'(TAPS);
    end else begin
      w_fill_next = r_fill + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= '0;
    end else if (i_load) begin
      r_fill <= w_fill_next;
    end
  end

  assign o_fill      = r_fill;
  assign o_fill_next = w_fill_next;
endmodule

// File: rtl/pixel_window_shift.sv
// Sliding window of the last TAPS pixels, newest in slot 0, never spanning two lines.
// Build macro PIXEL_WINDOW_EDGE_REPLICATE_EN: s_sol fills every slot with the first pixel.
module pixel_window_shift
  import pixel_pkg::*;
#(
  parameter int PIX_W = PIX_W_RGB,
  parameter int TAPS  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  pixel_window_shift_if.slave  bus
);
  localparam int CNT_W = $clog2(TAPS + 1);

  logic [PIX_W*TAPS-1:0] r_window;
  logic [PIX_W*TAPS-1:0] w_window_next;
  logic                  r_m_valid;
  logic                  r_m_eol;
  logic [CNT_W-1:0]      w_fill;
  logic [CNT_W-1:0]      w_fill_next;
  logic                  w_s_ready;
  logic                  w_accept;

  assign w_s_ready = !rst && (!r_m_valid || bus.m_ready);
  assign w_accept  = bus.s_valid && w_s_ready;

  always_comb begin
    w_window_next = {r_window[PIX_W*(TAPS-1)-1:0], bus.s_pixel};
`ifdef PIXEL_WINDOW_EDGE_REPLICATE_EN
    if (bus.s_sol) begin
      for (int k = 0; k < TAPS; k++) begin
        w_window_next[slot_lsb(k, PIX_W) +: PIX_W] = bus.s_pixel;
      end
    end
`endif
  end

  pixel_fill_cnt #(
    .TAPS  (TAPS),
    .CNT_W (CNT_W)
  ) u_fill_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_sol       (bus.s_sol),
    .o_fill      (w_fill),
    .o_fill_next (w_fill_next)
  );

  // A window is presented only once TAPS pixels of the current line are held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_window  <= '0;
      r_m_valid <= 1'b0;
      r_m_eol   <= 1'b0;
    end else if (w_accept) begin
      r_window  <= w_window_next;
      r_m_eol   <= bus.s_eol;
      r_m_valid <= (w_fill_next == CNT_W'(TAPS));
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign bus.s_ready  = w_s_ready;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_window = r_window;
  assign bus.m_eol    = r_m_eol;
  assign bus.fill     = w_fill;
endmodule

// File: tb/tb_pixel_window_shift.sv
// Directed bench for pixel_window_shift: RGB/3-tap vector table plus a gray/5-tap stream.
// Expectations follow the PIXEL_WINDOW_EDGE_REPLICATE_EN setting of the build.
module tb_pixel_window_shift;
  import pixel_pkg::*;

  localparam int AW = 24;
  localparam int AT = 3;
  localparam int BW = 8;
  localparam int BT = 5;

  typedef struct {
    logic           v;
    logic [AW-1:0]  pix;
    logic           sol;
    logic           eol;
    logic           mr;
    logic           exp_sr;
    logic           exp_mv;
    logic [AW*AT-1:0] exp_win;
    logic           exp_eol;
    logic [1:0]     exp_fill;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];
  vec_t post_rst[$];
  logic [BW*BT-1:0] exp_q[$];
  logic [BW*BT-1:0] obs_q[$];

  pixel_window_shift_if #(.PIX_W(AW), .TAPS(AT)) bus_a ();
  pixel_window_shift_if #(.PIX_W(BW), .TAPS(BT)) bus_b ();

  pixel_window_shift #(.PIX_W(AW), .TAPS(AT)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pixel_window_shift #(.PIX_W(BW), .TAPS(BT)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW*AT-1:0] w3(input logic [AW-1:0] a, b, c);
    return {a, b, c};
  endfunction

  function automatic vec_t mk(input logic v, input logic [AW-1:0] pix, input logic sol, eol, mr,
                              input logic sr, mv, input logic [AW*AT-1:0] win,
                              input logic e, input logic [1:0] f);
    vec_t r;
    r.v = v; r.pix = pix; r.sol = sol; r.eol = eol; r.mr = mr;
    r.exp_sr = sr; r.exp_mv = mv; r.exp_win = win; r.exp_eol = e; r.exp_fill = f;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    bus_a.s_valid = v.v;
    bus_a.s_pixel = v.pix;
    bus_a.s_sol   = v.sol;
    bus_a.s_eol   = v.eol;
    bus_a.m_ready = v.mr;
    #3;
    check({tag, "_s_ready"}, 128'(bus_a.s_ready), 128'(v.exp_sr));
    @(posedge clk); #1;
    check({tag, "_m_valid"},  128'(bus_a.m_valid),  128'(v.exp_mv));
    check({tag, "_m_window"}, 128'(bus_a.m_window), 128'(v.exp_win));
    check({tag, "_m_eol"},    128'(bus_a.m_eol),    128'(v.exp_eol));
    check({tag, "_fill"},     128'(bus_a.fill),     128'(v.exp_fill));
  endtask

  initial begin
    logic [AW*AT-1:0] last_win;
    logic [AW-1:0] F, G, A1, A2, A3;
    n_tests = 0;
    n_fail  = 0;
    F = 24'hFF0000; G = 24'h00FF00;
    A1 = 24'hA00001; A2 = 24'hA00002; A3 = 24'hA00003;

`ifdef PIXEL_WINDOW_EDGE_REPLICATE_EN
    vecs.push_back(mk(1, F, 1, 0, 1, 1, 1, w3(F, F, F), 0, 3));
    vecs.push_back(mk(1, G, 0, 0, 1, 1, 1, w3(F, F, G), 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, w3(F, F, G), 0, 3));
    vecs.push_back(mk(1, 16, 1, 1, 0, 1, 1, w3(16, 16, 16), 1, 3));
    vecs.push_back(mk(1, 17, 0, 0, 0, 0, 1, w3(16, 16, 16), 1, 3));
    vecs.push_back(mk(1, 17, 0, 0, 1, 1, 1, w3(16, 16, 17), 0, 3));
    post_rst.push_back(mk(1, 40, 1, 0, 1, 1, 1, w3(40, 40, 40), 0, 3));
    post_rst.push_back(mk(1, 41, 0, 0, 1, 1, 1, w3(40, 40, 41), 0, 3));
    post_rst.push_back(mk(1, 42, 0, 0, 1, 1, 1, w3(40, 41, 42), 0, 3));
    exp_q.push_back({8'd1, 8'd1, 8'd1, 8'd1, 8'd1});
    exp_q.push_back({8'd1, 8'd1, 8'd1, 8'd1, 8'd2});
    exp_q.push_back({8'd1, 8'd1, 8'd1, 8'd2, 8'd3});
    exp_q.push_back({8'd1, 8'd1, 8'd2, 8'd3, 8'd4});
    exp_q.push_back({8'd1, 8'd2, 8'd3, 8'd4, 8'd5});
    exp_q.push_back({8'd2, 8'd3, 8'd4, 8'd5, 8'd6});
    exp_q.push_back({8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
`else
    // fill
    vecs.push_back(mk(1, A1, 1, 0, 1, 1, 0, w3(0, 0, A1), 0, 1));
    vecs.push_back(mk(1, A2, 0, 0, 1, 1, 0, w3(0, A1, A2), 0, 2));
    vecs.push_back(mk(1, A3, 0, 0, 1, 1, 1, w3(A1, A2, A3), 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, w3(A1, A2, A3), 0, 3));
    // stall
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 0, w3(A2, A3, 1), 0, 1));
    vecs.push_back(mk(1, 2, 0, 0, 1, 1, 0, w3(A3, 1, 2), 0, 2));
    vecs.push_back(mk(1, 3, 0, 0, 0, 1, 1, w3(1, 2, 3), 0, 3));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 4, 0, 0, 0, 0, 1, w3(1, 2, 3), 0, 3));
    vecs.push_back(mk(1, 4, 0, 0, 1, 1, 1, w3(2, 3, 4), 0, 3));
    vecs.push_back(mk(1, 5, 0, 0, 1, 1, 1, w3(3, 4, 5), 0, 3));
    vecs.push_back(mk(1, 6, 0, 1, 1, 1, 1, w3(4, 5, 6), 1, 3));
    // line break
    vecs.push_back(mk(1, 10, 1, 0, 1, 1, 0, w3(5, 6, 10), 0, 1));
    vecs.push_back(mk(1, 11, 0, 0, 1, 1, 0, w3(6, 10, 11), 0, 2));
    vecs.push_back(mk(1, 12, 0, 0, 1, 1, 1, w3(10, 11, 12), 0, 3));
    vecs.push_back(mk(1, 13, 0, 1, 1, 1, 1, w3(11, 12, 13), 1, 3));
    vecs.push_back(mk(1, 20, 1, 0, 1, 1, 0, w3(12, 13, 20), 0, 1));
    vecs.push_back(mk(1, 21, 0, 0, 1, 1, 0, w3(13, 20, 21), 0, 2));
    vecs.push_back(mk(1, 22, 0, 0, 1, 1, 1, w3(20, 21, 22), 0, 3));
    // one-pixel line, flags ignored without valid, continuation, saturation
    vecs.push_back(mk(1, 30, 1, 1, 1, 1, 0, w3(21, 22, 30), 1, 1));
    vecs.push_back(mk(0, 99, 1, 0, 1, 1, 0, w3(21, 22, 30), 1, 1));
    vecs.push_back(mk(1, 31, 0, 0, 1, 1, 0, w3(22, 30, 31), 0, 2));
    vecs.push_back(mk(1, 32, 0, 0, 1, 1, 1, w3(30, 31, 32), 0, 3));
    vecs.push_back(mk(1, 33, 0, 0, 1, 1, 1, w3(31, 32, 33), 0, 3));
    post_rst.push_back(mk(1, 40, 1, 0, 1, 1, 0, w3(0, 0, 40), 0, 1));
    post_rst.push_back(mk(1, 41, 0, 0, 1, 1, 0, w3(0, 40, 41), 0, 2));
    post_rst.push_back(mk(1, 42, 0, 0, 1, 1, 1, w3(40, 41, 42), 0, 3));
    exp_q.push_back({8'd1, 8'd2, 8'd3, 8'd4, 8'd5});
    exp_q.push_back({8'd2, 8'd3, 8'd4, 8'd5, 8'd6});
    exp_q.push_back({8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
`endif

    // clock/reset
    rst = 1'b1;
    bus_a.s_valid = 0; bus_a.s_pixel = '0; bus_a.s_sol = 0; bus_a.s_eol = 0; bus_a.m_ready = 1;
    bus_b.s_valid = 0; bus_b.s_pixel = '0; bus_b.s_sol = 0; bus_b.s_eol = 0; bus_b.m_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready",  128'(bus_a.s_ready),  128'(0));
    check("rst_m_valid",  128'(bus_a.m_valid),  128'(0));
    check("rst_m_window", 128'(bus_a.m_window), 128'(0));
    check("rst_m_eol",    128'(bus_a.m_eol),    128'(0));
    check("rst_fill",     128'(bus_a.fill),     128'(0));
    rst = 1'b0;

    foreach (vecs[i]) apply_vec($sformatf("v%0d", i), vecs[i]);
    last_win = vecs[vecs.size()-1].exp_win;

    // reset while a window is stalled
    bus_a.s_valid = 1; bus_a.s_pixel = 24'd34; bus_a.s_sol = 0; bus_a.s_eol = 0; bus_a.m_ready = 0;
    #3;
    check("stall_s_ready", 128'(bus_a.s_ready), 128'(0));
    @(posedge clk); #1;
    check("stall_m_valid",  128'(bus_a.m_valid),  128'(1));
    check("stall_m_window", 128'(bus_a.m_window), 128'(last_win));
    rst = 1'b1;
    bus_a.m_ready = 1;
    #3;
    check("in_rst_s_ready", 128'(bus_a.s_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_m_valid",  128'(bus_a.m_valid),  128'(0));
    check("mid_rst_fill",     128'(bus_a.fill),     128'(0));
    check("mid_rst_m_window", 128'(bus_a.m_window), 128'(0));
    foreach (post_rst[i]) apply_vec($sformatf("post_rst%0d", i), post_rst[i]);
    bus_a.s_valid = 0;

    // gray 5-tap stream, one window collected per m_valid cycle
    for (int p = 1; p <= 7; p++) begin
      bus_b.s_valid = 1;
      bus_b.s_pixel = 8'(p);
      bus_b.s_sol   = (p == 1);
      @(posedge clk); #1;
      if (bus_b.m_valid) obs_q.push_back(bus_b.m_window);
    end
    bus_b.s_valid = 0;
    bus_b.s_sol   = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus_b.m_valid) obs_q.push_back(bus_b.m_window);
    end
    check("b_window_count", 128'(obs_q.size()), 128'(exp_q.size()));
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      logic [BW*BT-1:0] e;
      logic [BW*BT-1:0] o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check($sformatf("b_window%0d", i), 128'(o), 128'(e));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
